mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction-fetch requester and the data (load/store) requester of the pipelined core.
- Sits between the core's fetch/memory stages and the memory model. It sequences one access at a time with a valid/ready handshake.
- Data accesses win by default. A bounded-streak rule guarantees that fetch makes forward progress.

Parameters:
- D_STREAK_MAX, 4, max consecutive data grants issued while a fetch is pending before fetch is forced; legal range >= 1
- XLEN, 32, address/data width

Ports:
- clk  input  1  clock; all state updates on posedge clk
- reset  input  1  synchronous, active-high reset
- i_valid  input  1  fetch request; held with i_addr stable until i_ready
- i_addr  input  XLEN  fetch address
- i_ready  output  1  one-cycle completion pulse for fetch
- i_rdata  output  XLEN  fetched instruction; valid only when i_ready=1
- d_valid  input  1  data request; held with d_* stable until d_ready
- d_addr  input  XLEN  data address
- d_wen  input  1  1 = store, 0 = load
- d_wmask  input  XLEN  store byte/bit mask
- d_wdata  input  XLEN  store data
- d_ready  output  1  one-cycle completion pulse for data
- d_rdata  output  XLEN  load data; valid only when d_ready=1 and the access was a load
- mem_valid  output  1  access request to memory (registered)
- mem_addr  output  XLEN  registered address
- mem_wen  output  1  registered write enable; 0 for fetch
- mem_wmask  output  XLEN  registered mask; 0 for fetch
- mem_wdata  output  XLEN  registered write data; 0 for fetch
- mem_rdata  input  XLEN  memory read data, valid with mem_ready
- mem_ready  input  1  memory completion, single-cycle pulse
- busy  output  1  state != IDLE

Behaviour:
- Reset state:
  - state=IDLE, streak=0.
  - mem_valid=0, mem_addr=0, mem_wen=0, mem_wmask=0, mem_wdata=0.
  - i_ready=0, d_ready=0, busy=0.
- Reset mid-access:
  - Returns to IDLE at the reset edge and drops mem_valid the next cycle.
  - No ready pulse is issued for the aborted access.
  - A late mem_ready after reset is ignored.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE, evaluated at each posedge:
  - No request -> stay IDLE.
  - Only i_valid -> GRANT_I.
  - Only d_valid -> GRANT_D.
  - Both valid, streak < D_STREAK_MAX -> GRANT_D.
  - Both valid, streak == D_STREAK_MAX -> GRANT_I.
- On the grant edge:
  - mem_valid <= 1 and the mem_* fields are loaded from the winner.
  - Fetch loads mem_wen=0, mem_wmask=0, mem_wdata=0.
- GRANT_x:
  - mem_valid and mem_* stay stable until mem_ready=1.
  - In the mem_ready cycle, x_ready = 1 combinationally and x_rdata = mem_rdata.
  - At that edge: state <= IDLE, mem_valid <= 0.
- Ready signals:
  - i_ready = (state==GRANT_I) & mem_ready.
  - d_ready = (state==GRANT_D) & mem_ready.
  - Never both high.
  - i_rdata and d_rdata pass mem_rdata through at all times and are meaningful only with their ready.
- mem_ready while in IDLE is ignored; no state change, no ready pulse.
- Latency:
  - Request seen at edge N -> mem_valid high in cycle N+1.
  - Earliest x_ready is cycle N+1 (when mem_ready is high in that same cycle).
  - One IDLE cycle always separates accesses, so peak throughput is 1 access per 2 cycles.
- Streak counter, width clog2(D_STREAK_MAX+1), updated at grant edges only:
  - Data grant while i_valid=1 -> streak+1, saturating at D_STREAK_MAX.
  - Data grant while i_valid=0 -> streak=0.
  - Any fetch grant -> streak=0.
- Requester changes:
  - A requester may drop valid or present a new request in the cycle after its ready pulse; no combinational path from valid to ready.
  - Changing a held request before ready is a protocol violation; the arbiter uses the values latched at grant.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, no requests, mem_ready=1 pulses -> mem_valid=0, i_ready=d_ready=0, busy=0 throughout.
- Single fetch:
  - Stimulus: i_valid=1, i_addr=0x100; memory returns 0x00000013 with mem_ready in the first mem_valid cycle.
  - Required: mem_addr=0x100, mem_wen=0; i_ready pulses exactly once, 1 cycle after i_valid, with i_rdata=0x00000013.
- Store with wait states:
  - Stimulus: d_valid=1, d_wen=1, d_addr=0x200, d_wmask=0x0000FFFF, d_wdata=0xDEADBEEF; mem_ready delayed 3 cycles.
  - Required: mem_* held stable for 4 cycles; d_ready pulses once; mem_valid=0 the following cycle.
- Contention/starvation (D_STREAK_MAX=4):
  - Stimulus: i_valid and d_valid both held high continuously; mem_ready=1 always.
  - Required grant order: D, D, D, D, I, D, D, D, D, I.
  - Each completion is followed by 1 IDLE cycle.
- Reset mid-access: assert reset while in GRANT_D before mem_ready -> no d_ready; mem_valid=0 next cycle; a stale mem_ready one cycle later produces no ready pulse.
- Stray mem_ready in IDLE: pulse mem_ready with no request -> no ready pulses, state stays IDLE, streak unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a shared single-port memory
module mem_port_arbiter #(
    parameter int D_STREAK_MAX = 4,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ready,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_valid,
    input  logic [XLEN-1:0] d_addr,
    input  logic            d_wen,
    input  logic [XLEN-1:0] d_wmask,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ready,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wmask,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            busy
);

    localparam int SW = $clog2(D_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK_MAX);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] streak;
    logic          grant_i;
    logic          grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Data wins unless fetch has waited out a full streak of data grants.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid && (!d_valid || streak == STREAK_MAX)) begin
                    grant_i    = 1'b1;
                    state_next = GRANT_I;
                end else if (d_valid) begin
                    grant_d    = 1'b1;
                    state_next = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak    <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wmask <= '0;
            mem_wdata <= '0;
        end else if (grant_i) begin
            streak    <= '0;
            mem_valid <= 1'b1;
            mem_addr  <= i_addr;
            mem_wen   <= 1'b0;
            mem_wmask <= '0;
            mem_wdata <= '0;
        end else if (grant_d) begin
            if (!i_valid) begin
                streak <= '0;
            end else if (streak != STREAK_MAX) begin
                streak <= streak + 1'b1;
            end
            mem_valid <= 1'b1;
            mem_addr  <= d_addr;
            mem_wen   <= d_wen;
            mem_wmask <= d_wmask;
            mem_wdata <= d_wdata;
        end else if (state != IDLE && mem_ready) begin
            mem_valid <= 1'b0;
        end
    end

    assign i_ready = (state == GRANT_I) && mem_ready;
    assign d_ready = (state == GRANT_D) && mem_ready;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            i_valid;
    logic [XLEN-1:0] i_addr;
    logic            i_ready;
    logic [XLEN-1:0] i_rdata;
    logic            d_valid;
    logic [XLEN-1:0] d_addr;
    logic            d_wen;
    logic [XLEN-1:0] d_wmask;
    logic [XLEN-1:0] d_wdata;
    logic            d_ready;
    logic [XLEN-1:0] d_rdata;
    logic            mem_valid;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [XLEN-1:0] mem_wmask;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;
    logic            busy;

    logic            resp_ready  = 1'b0;
    logic            force_ready = 1'b0;
    logic [XLEN-1:0] resp_rdata  = '0;
    bit              auto_en     = 1'b1;
    int              mem_delay   = 0;
    int              wait_cnt    = 0;

    typedef struct {
        logic            is_d;
        logic [XLEN-1:0] addr;
        logic            wen;
        logic [XLEN-1:0] wmask;
        logic [XLEN-1:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   passes   = 0;
    int   done_cnt = 0;
    bit   prev_rdy = 1'b0;

    assign mem_ready = resp_ready | force_ready;
    assign mem_rdata = resp_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.D_STREAK_MAX(4), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_addr(d_addr), .d_wen(d_wen), .d_wmask(d_wmask),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy)
    );

    function automatic logic [XLEN-1:0] mem_data(input logic [XLEN-1:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void push_i(input logic [XLEN-1:0] a);
        exp_t e;
        e.is_d = 1'b0; e.addr = a; e.wen = 1'b0; e.wmask = '0; e.wdata = '0;
        sb.push_back(e);
    endfunction

    function automatic void push_d(input logic [XLEN-1:0] a, input logic w,
                                   input logic [XLEN-1:0] m, input logic [XLEN-1:0] dt);
        exp_t e;
        e.is_d = 1'b1; e.addr = a; e.wen = w; e.wmask = m; e.wdata = dt;
        sb.push_back(e);
    endfunction

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) break;
        end
        check(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    // Memory model: answers after mem_delay wait cycles while auto_en is set.
    always @(posedge clk) begin
        #1;
        if (auto_en && mem_valid && !reset) begin
            if (wait_cnt >= mem_delay) begin
                resp_ready = 1'b1;
                resp_rdata = mem_data(mem_addr);
                wait_cnt   = 0;
            end else begin
                resp_ready = 1'b0;
                wait_cnt   = wait_cnt + 1;
            end
        end else begin
            resp_ready = 1'b0;
            wait_cnt   = 0;
        end
    end

    // Completion monitor: pops the scoreboard on every ready pulse.
    always @(negedge clk) begin
        exp_t e;
        if (prev_rdy) begin
            check("gap_busy", 32'(busy), 32'd0);
            check("gap_mem_valid", 32'(mem_valid), 32'd0);
        end
        if (i_ready || d_ready) begin
            check("ready_onehot", 32'(i_ready & d_ready), 32'd0);
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_kind", 32'(d_ready), 32'(e.is_d));
                check("sb_addr", mem_addr, e.addr);
                check("sb_wen", 32'(mem_wen), 32'(e.wen));
                check("sb_wmask", mem_wmask, e.wmask);
                check("sb_wdata", mem_wdata, e.wdata);
                if (!e.is_d) check("sb_i_rdata", i_rdata, mem_data(e.addr));
                else if (!e.wen) check("sb_d_rdata", d_rdata, mem_data(e.addr));
            end
            done_cnt++;
        end
        prev_rdy = i_ready | d_ready;
    end

    initial begin
        reset   = 1'b1;
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_addr = '0; d_wen = 1'b0; d_wmask = '0; d_wdata = '0;

        // Reset held two cycles with stray mem_ready pulses.
        for (int k = 0; k < 2; k++) begin
            force_ready = (k == 1);
            @(negedge clk);
            check("rst_mem_valid", 32'(mem_valid), 32'd0);
            check("rst_mem_addr", mem_addr, 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_i_ready", 32'(i_ready), 32'd0);
            check("rst_d_ready", 32'(d_ready), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0; force_ready = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(i_ready | d_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        force_ready = 1'b0;
        @(negedge clk);
        check("idle_mem_valid", 32'(mem_valid), 32'd0);

        // Single fetch with zero wait states.
        @(posedge clk); #1;
        i_valid = 1'b1; i_addr = 32'h100;
        push_i(32'h100);
        @(negedge clk);
        check("fetch_early_ready", 32'(i_ready), 32'd0);
        check("fetch_early_valid", 32'(mem_valid), 32'd0);
        @(negedge clk);
        check("fetch_ready", 32'(i_ready), 32'd1);
        check("fetch_addr", mem_addr, 32'h100);
        check("fetch_wen", 32'(mem_wen), 32'd0);
        check("fetch_rdata", i_rdata, 32'h0000_0013);
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("fetch_once", 32'(i_ready), 32'd0);

        // Store with three wait states.
        @(posedge clk); #1;
        mem_delay = 3;
        d_valid = 1'b1; d_wen = 1'b1; d_addr = 32'h200;
        d_wmask = 32'h0000_FFFF; d_wdata = 32'hDEAD_BEEF;
        push_d(32'h200, 1'b1, 32'h0000_FFFF, 32'hDEAD_BEEF);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("st_valid", 32'(mem_valid), 32'd1);
            check("st_addr", mem_addr, 32'h200);
            check("st_wen", 32'(mem_wen), 32'd1);
            check("st_wmask", mem_wmask, 32'h0000_FFFF);
            check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("st_d_ready", 32'(d_ready), 32'(k == 3));
        end
        @(posedge clk); #1;
        d_valid = 1'b0; d_wen = 1'b0; mem_delay = 0;
        @(negedge clk);
        check("st_sb_drained", 32'(sb.size()), 32'd0);

        // Contention: both requesters held, fetch forced after four data grants.
        @(posedge clk); #1;
        i_valid = 1'b1; i_addr = 32'h300;
        d_valid = 1'b1; d_wen = 1'b0; d_addr = 32'h400; d_wmask = '0; d_wdata = '0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) push_d(32'h400, 1'b0, '0, '0);
            push_i(32'h300);
        end
        wait_done(done_cnt + 10, 100, "contention_timeout");
        @(posedge clk); #1;
        i_valid = 1'b0; d_valid = 1'b0;
        @(negedge clk);
        check("cont_sb_drained", 32'(sb.size()), 32'd0);

        // Reset while a data access is outstanding, then a stale mem_ready.
        auto_en = 1'b0;
        @(posedge clk); #1;
        d_valid = 1'b1; d_addr = 32'h500; d_wen = 1'b1; d_wmask = '1; d_wdata = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        check("rma_busy", 32'(busy), 32'd1);
        check("rma_mem_valid", 32'(mem_valid), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; d_valid = 1'b0;
        @(negedge clk);
        check("rma_no_ready", 32'(d_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; force_ready = 1'b1;
        @(negedge clk);
        check("rma_mem_valid_drop", 32'(mem_valid), 32'd0);
        check("rma_stale_ready", 32'(d_ready | i_ready), 32'd0);
        check("rma_busy_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;
        force_ready = 1'b0;

        // Stray mem_ready in IDLE.
        @(posedge clk); #1;
        force_ready = 1'b1;
        @(negedge clk);
        check("stray_ready", 32'(d_ready | i_ready), 32'd0);
        @(posedge clk); #1;
        force_ready = 1'b0;
        @(negedge clk);
        check("stray_busy", 32'(busy), 32'd0);
        check("stray_mem_valid", 32'(mem_valid), 32'd0);

        // Arbitration still starts from a data grant with a fresh streak.
        auto_en = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b1; i_addr = 32'h600;
        d_valid = 1'b1; d_wen = 1'b0; d_addr = 32'h700; d_wmask = '0; d_wdata = '0;
        for (int k = 0; k < 4; k++) push_d(32'h700, 1'b0, '0, '0);
        push_i(32'h600);
        wait_done(done_cnt + 5, 60, "post_reset_timeout");
        @(posedge clk); #1;
        i_valid = 1'b0; d_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("final_sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
